mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage, driven by the decoder's `mem_read`/`mem_write`). The arbiter allows at most one outstanding read, holds each selection until the memory accepts it, and routes read data back to the owner. It sits between the pipeline's two memory clients and the memory/bus model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `DM_STREAK_MAX`, 4, consecutive data grants allowed while a fetch waits; used only with the fairness macro
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted by memory
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  DATA_W  fetch read data
- `dm_req`  in  1  data request; held with `dm_we`, `dm_be`, `dm_addr`, `dm_wdata` until `dm_gnt`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_be`  in  DATA_W/8  byte enables
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  data request accepted
- `dm_rvalid`  out  1  one-cycle pulse; load data valid (loads only)
- `dm_rdata`  out  DATA_W  load data
- `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory request bus
- `mem_ready`  in  1  memory accepts the request this cycle (`mem_req & mem_ready`)
- `mem_rvalid`  in  1  read response valid
- `mem_rdata`  in  DATA_W  read response data
- `busy`  out  1  high in `WAIT_IF` or `WAIT_DM`

## Operation
- FSM has three states: `IDLE`, `WAIT_IF`, `WAIT_DM`. Reset state is `IDLE`.
- **IDLE, nothing locked:** select the owner from current requests.
  - Default priority: data over fetch.
  - `mem_*` is driven combinationally from the selected requester.
- **Lock:** if `mem_req` is high and `mem_ready` is low, register `lock_valid` and `lock_owner`.
  - The selection cannot change until acceptance, even if a higher-priority request appears.
- **Acceptance** (`mem_req & mem_ready`):
  - Pulse the owner's gnt in the same cycle and clear the lock.
  - Load or fetch: go to `WAIT_DM` or `WAIT_IF`.
  - Store: the transaction is complete; stay in `IDLE`, and no rvalid is produced.
- **WAIT_x:** `mem_req`=0. On `mem_rvalid`, pulse `x_rvalid` with `x_rdata`=`mem_rdata`, then return to `IDLE`.
- `mem_rvalid` in `IDLE` is spurious and ignored; no rvalid is forwarded.
- `if_rdata`/`dm_rdata` are combinationally equal to `mem_rdata`; they are only meaningful while the matching rvalid is high.
- Deasserting a req before its gnt is a protocol violation; behaviour is undefined. This is flagged by an assertion.

## Timing
- All outputs are 0 while `rst_n` is low. Combinational `mem_*` and gnt outputs are gated by reset.
- Grant latency: the request appears on `mem_req` in the same cycle as `x_req` (IDLE, no lock). The gnt is in the cycle where `mem_ready`=1.
- Response: the earliest is `mem_rvalid` in the cycle after acceptance, forwarded in that same cycle.
- The next arbitration is the cycle after the response. Back-to-back reads therefore issue at most one request every 2 cycles.
- Stores can be accepted in consecutive cycles.
- **Simultaneous `if_req`/`dm_req` in IDLE:** the data request wins unless the fairness override applies.
- **Reset mid-operation:** the outstanding read is dropped, and lock and streak are cleared. A late `mem_rvalid` after reset lands in `IDLE` and is ignored.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A streak counter, `$clog2(DM_STREAK_MAX+1)` bits, increments on each `dm_gnt` while `if_req` is high.
  - It clears on `if_gnt` or when `if_req` is low.
  - When it equals `DM_STREAK_MAX`, the next unlocked selection picks fetch over data.
- `MEM_ARB_FAIR_EN` undefined: fixed data-over-fetch priority; no counter exists.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`/`WAIT_IF`/`WAIT_DM`);
  - the owner enum `arb_owner_t` (`OWN_IF`/`OWN_DM`).
- One sub-module, `mem_arb_select`: the priority pick and (when enabled) the streak counter. Its output is the selected owner.
- The FSM, lock register and muxing stay in the top level.

## Test plan
- **Lone fetch, zero wait:** `if_req`, `if_addr`=0x100, `mem_ready`=1, `mem_rdata`=0x00500093 next cycle → `if_gnt` at cycle 0, `if_rvalid` plus data at cycle 1, `busy` high for 1 cycle.
- **Collision with lock:** `if_req` only, `mem_ready`=0 for 3 cycles, `dm_req` rises at cycle 1 → `mem_addr` stays the fetch address until `if_gnt`. The data request is served after the response.
- **Store then load:** `dm_we`=1 to 0x200 with `dm_be`=0xF and `dm_wdata`=0xDEADBEEF, accepted → no `dm_rvalid`, state stays `IDLE`. The following load of 0x200 returns `dm_rvalid` with 0xDEADBEEF.
- **Spurious and reset cases:**
  - `mem_rvalid` pulse in `IDLE` → no rvalid to either port.
  - Reset asserted while in `WAIT_DM` → all outputs 0, state `IDLE`, no `dm_rvalid` afterwards.
- **Fairness** (`MEM_ARB_FAIR_EN`, `DM_STREAK_MAX`=4): continuous stores with `if_req` high → after exactly 4 `dm_gnt`s the next gnt is `if_gnt`.
  - Without the macro, `if_gnt` never occurs while `dm_req` is held.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM state and bus owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_select.sv
// Priority pick between fetch and data requests.
// Optional feature macro: MEM_ARB_FAIR_EN. When defined, a streak counter
// limits how many data grants may go by while a fetch is waiting. After
// DM_STREAK_MAX of them, the next unlocked pick goes to fetch.
// Without the macro the pick is a fixed data-over-fetch priority.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int DM_STREAK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       if_gnt,
  input  logic       dm_gnt,
  output arb_owner_t sel_owner
);

`ifdef MEM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(DM_STREAK_MAX + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX_C = CNT_W'(DM_STREAK_MAX);

  logic [CNT_W-1:0] streak_reg;
  logic             fetch_turn;

  assign fetch_turn = (streak_reg == STREAK_MAX_C);

  // Count data grants that overtake a waiting fetch; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else if (!if_req || if_gnt) begin
      streak_reg <= '0;
    end else if (dm_gnt && !fetch_turn) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

  // Data wins unless fetch has waited out a full streak.
  always_comb begin
    sel_owner = OWN_DM;
    if (if_req && (!dm_req || fetch_turn)) begin
      sel_owner = OWN_IF;
    end
  end
`else
  // Without fairness the clock, reset and grants play no part in the pick.
  logic unused_sel_inputs;
  localparam int unused_streak_max = DM_STREAK_MAX;
  assign unused_sel_inputs = &{1'b0, clk, rst_n, if_gnt, dm_gnt};

  // Fixed priority: data over fetch.
  always_comb begin
    sel_owner = OWN_DM;
    if (if_req && !dm_req) begin
      sel_owner = OWN_IF;
    end
  end
`endif

endmodule : mem_arb_select

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data.
// At most one read is outstanding; a presented request is locked until the
// memory accepts it, and read data is routed back to whichever port owns it.
// Optional feature macro: MEM_ARB_FAIR_EN (fetch starvation guard inside
// mem_arb_select).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DM_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  // memory bus
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state_reg;
  logic       lock_valid;
  arb_owner_t lock_owner;
  arb_owner_t sel_owner;
  arb_owner_t cur_owner;
  logic       owner_req;
  logic       accept;
  logic       own_dm;

  mem_arb_select #(
    .DM_STREAK_MAX (DM_STREAK_MAX)
  ) u_select (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .if_gnt    (if_gnt),
    .dm_gnt    (dm_gnt),
    .sel_owner (sel_owner)
  );

  // A locked owner keeps the bus until acceptance, regardless of new requests.
  always_comb begin
    cur_owner = lock_valid ? lock_owner : sel_owner;
    own_dm    = (cur_owner == OWN_DM);
    owner_req = own_dm ? dm_req : if_req;
  end

  // Request bus and grants; everything is forced low while in reset.
  always_comb begin
    mem_req   = rst_n && (state_reg == IDLE) && owner_req;
    accept    = mem_req && mem_ready;
    if_gnt    = accept && !own_dm;
    dm_gnt    = accept && own_dm;
    mem_we    = rst_n && own_dm && dm_we;
    mem_addr  = !rst_n ? '0 : (own_dm ? dm_addr : if_addr);
    mem_wdata = (rst_n && own_dm) ? dm_wdata : '0;
  end

  // Byte enables per lane: fetches always read the full word.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
    assign mem_be[gi] = rst_n && (own_dm ? dm_be[gi] : 1'b1);
  end

  // Response routing: rvalid only forwarded in the matching wait state.
  always_comb begin
    if_rvalid = rst_n && (state_reg == WAIT_IF) && mem_rvalid;
    dm_rvalid = rst_n && (state_reg == WAIT_DM) && mem_rvalid;
    if_rdata  = rst_n ? mem_rdata : '0;
    dm_rdata  = rst_n ? mem_rdata : '0;
    busy      = rst_n && (state_reg != IDLE);
  end

  // Arbiter FSM with lock register: IDLE issues, WAIT_x awaits the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      lock_valid <= 1'b0;
      lock_owner <= OWN_DM;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            lock_valid <= 1'b0;
            if (!own_dm) begin
              state_reg <= WAIT_IF;
            end else if (!dm_we) begin
              state_reg <= WAIT_DM;
            end
          end else if (mem_req) begin
            lock_valid <= 1'b1;
            lock_owner <= cur_owner;
          end
        end
        WAIT_IF, WAIT_DM: begin
          if (mem_rvalid) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A locked requester must keep its request up until it is granted.
  a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == IDLE && lock_valid && lock_owner == OWN_IF) |-> if_req);
  a_dm_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == IDLE && lock_valid && lock_owner == OWN_DM) |-> dm_req);
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change just after the falling
// edge; outputs are checked 1 time unit later, well before the rising edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int total;
  int bad;

  mem_port_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .DM_STREAK_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Advance to just after the next falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear_inputs();
    rst_n = 0;

    // ---- reset: all outputs low even with requests pending ----
    next_cycle();
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_addr = 32'h88; dm_we = 1;
    dm_be = 4'hF; dm_wdata = 32'h1234; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hABCD;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
    chk("rst_bus", {mem_we, mem_be, mem_addr, mem_wdata[23:0]}, 0);
    chk("rst_rdata", if_rdata, 0);
    $display("txn reset");
    next_cycle();
    clear_inputs();
    rst_n = 1;
    #1;
    chk("idle_busy", busy, 0);

    // ---- lone fetch, zero wait ----
    next_cycle();
    if_req = 1; if_addr = 32'h100; mem_ready = 1;
    #1;
    chk("f0_mem_req", mem_req, 1);
    chk("f0_mem_addr", mem_addr, 32'h100);
    chk("f0_mem_be", mem_be, 4'hF);
    chk("f0_if_gnt", if_gnt, 1);
    chk("f0_dm_gnt", dm_gnt, 0);
    chk("f0_busy", busy, 0);
    next_cycle();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    #1;
    chk("f1_busy", busy, 1);
    chk("f1_if_rvalid", if_rvalid, 1);
    chk("f1_if_rdata", if_rdata, 32'h00500093);
    chk("f1_dm_rvalid", dm_rvalid, 0);
    chk("f1_mem_req", mem_req, 0);
    next_cycle();
    mem_rvalid = 0;
    #1;
    chk("f2_busy", busy, 0);
    chk("f2_if_rvalid", if_rvalid, 0);
    $display("txn lone fetch addr=100");

    // ---- collision with lock ----
    next_cycle();
    if_req = 1; if_addr = 32'h104; mem_ready = 0;
    #1;
    chk("c0_mem_req", mem_req, 1);
    chk("c0_mem_addr", mem_addr, 32'h104);
    chk("c0_if_gnt", if_gnt, 0);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h300;
      #1;
      chk("c_lock_addr", mem_addr, 32'h104);
      chk("c_lock_gnt", {if_gnt, dm_gnt}, 0);
    end
    next_cycle();
    mem_ready = 1;
    #1;
    chk("c3_mem_addr", mem_addr, 32'h104);
    chk("c3_gnt", {if_gnt, dm_gnt}, 2'b10);
    next_cycle();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
    #1;
    chk("c4_if_rvalid", if_rvalid, 1);
    chk("c4_if_rdata", if_rdata, 32'h11111111);
    chk("c4_mem_req", mem_req, 0);
    chk("c4_dm_gnt", dm_gnt, 0);
    next_cycle();
    mem_rvalid = 0; mem_ready = 1;
    #1;
    chk("c5_mem_addr", mem_addr, 32'h300);
    chk("c5_dm_gnt", dm_gnt, 1);
    chk("c5_mem_we", mem_we, 0);
    next_cycle();
    dm_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h22222222;
    #1;
    chk("c6_dm_rvalid", dm_rvalid, 1);
    chk("c6_dm_rdata", dm_rdata, 32'h22222222);
    chk("c6_if_rvalid", if_rvalid, 0);
    next_cycle();
    clear_inputs();
    #1;
    chk("c7_busy", busy, 0);
    $display("txn collision fetch=104 data=300");

    // ---- store then load ----
    next_cycle();
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; mem_ready = 1;
    #1;
    chk("s0_dm_gnt", dm_gnt, 1);
    chk("s0_bus", {mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 4'hF, 32'h200, 32'hDEADBEEF});
    next_cycle();
    clear_inputs();
    #1;
    chk("s1_busy", busy, 0);
    chk("s1_dm_rvalid", dm_rvalid, 0);
    next_cycle();
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h200; mem_ready = 1;
    #1;
    chk("l0_dm_gnt", dm_gnt, 1);
    chk("l0_mem_we", mem_we, 0);
    next_cycle();
    clear_inputs();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("l1_busy", busy, 1);
    chk("l1_dm_rvalid", dm_rvalid, 1);
    chk("l1_dm_rdata", dm_rdata, 32'hDEADBEEF);
    $display("txn store/load addr=200");

    // ---- spurious rvalid in IDLE ----
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h55;
    #1;
    chk("sp_rvalid", {if_rvalid, dm_rvalid}, 0);
    chk("sp_busy", busy, 0);
    $display("txn spurious rvalid");

    // ---- reset while in WAIT_DM ----
    next_cycle();
    clear_inputs();
    dm_req = 1; dm_addr = 32'h500; dm_be = 4'h3; mem_ready = 1;
    #1;
    chk("r0_dm_gnt", dm_gnt, 1);
    chk("r0_mem_be", mem_be, 4'h3);
    next_cycle();
    clear_inputs();
    #1;
    chk("r1_busy", busy, 1);
    next_cycle();
    rst_n = 0; mem_rvalid = 1; mem_rdata = 32'h77; dm_req = 1; mem_ready = 1;
    #1;
    chk("r2_busy", busy, 0);
    chk("r2_outs", {mem_req, dm_gnt, dm_rvalid, if_rvalid}, 0);
    next_cycle();
    rst_n = 1; dm_req = 0; mem_ready = 0;
    #1;
    chk("r3_dm_rvalid", dm_rvalid, 0);
    chk("r3_busy", busy, 0);
    next_cycle();
    clear_inputs();
    $display("txn reset in WAIT_DM");

    // ---- fairness / fixed priority under continuous stores ----
    next_cycle();
    if_req = 1; if_addr = 32'h400;
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h600; dm_wdata = 32'h9; mem_ready = 1;
`ifdef MEM_ARB_FAIR_EN
    for (int k = 0; k < 4; k++) begin
      if (k != 0) next_cycle();
      #1;
      chk("fair_dm_gnt", {if_gnt, dm_gnt}, 2'b01);
    end
    next_cycle();
    #1;
    chk("fair_if_gnt", {if_gnt, dm_gnt}, 2'b10);
    chk("fair_if_addr", mem_addr, 32'h400);
`else
    for (int k = 0; k < 8; k++) begin
      if (k != 0) next_cycle();
      #1;
      chk("fixed_dm_gnt", {if_gnt, dm_gnt}, 2'b01);
    end
    next_cycle();
    dm_req = 0;
    #1;
    chk("fixed_if_gnt", {if_gnt, dm_gnt}, 2'b10);
    chk("fixed_if_addr", mem_addr, 32'h400);
`endif
    next_cycle();
    clear_inputs();
    mem_rvalid = 1; mem_rdata = 32'hCAFE;
    #1;
    chk("fr_if_rvalid", if_rvalid, 1);
    chk("fr_dm_rvalid", dm_rvalid, 0);
    next_cycle();
    clear_inputs();
    #1;
    chk("fr_busy", busy, 0);
    $display("txn streak stores with fetch waiting");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
